fetch_ifid: RTL and testbench
=============================

FETCH_IFID -- requirements
Module: fetch_ifid

Interface
REQ-001 The module SHALL have parameter N, default 64, the datapath and PC width.
REQ-002 The module SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port stall_D  input  1  decode stage cannot accept a new instruction this cycle (hazard unit).
REQ-006 Port pcsrc_M  input  1  taken branch resolved in MEM; redirect fetch.
REQ-007 Port branch_target_M  input  N  redirect address.
REQ-008 Port imem_req  output  1  instruction memory request valid.
REQ-009 Port imem_addr  output  N  fetch address, equal to the current PC.
REQ-010 Port imem_ready  input  1  imem_rdata is valid this cycle for the requested imem_addr.
REQ-011 Port imem_rdata  input  32  instruction word.
REQ-012 Port instr_D  output  32  IF/ID instruction register, feeding the decode stage.
REQ-013 Port pc_D  output  N  PC of instr_D.
REQ-014 Port valid_D  output  1  instr_D holds a real instruction; 0 means a bubble.

Function
REQ-015 The module SHALL implement the states BOOT, FETCH and HOLD, plus a 32-bit skid register.
REQ-016 BOOT SHALL last exactly one cycle after reset release, with imem_req=0, then go to FETCH.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC; imem_addr SHALL stay stable until imem_ready, except on a redirect.
REQ-018 In FETCH with imem_ready=1 and stall_D=0, the module SHALL:
- load instr_D<=imem_rdata, pc_D<=PC, valid_D<=1;
- set PC<=PC+4, with modulo 2^N wrap-around.
- Fetch-to-decode latency is therefore 1 cycle after imem_ready.
REQ-019 In FETCH with imem_ready=1 and stall_D=1, the module SHALL:
- capture imem_rdata into the skid register;
- hold the PC and the IF/ID register;
- go to HOLD.
REQ-020 In FETCH with imem_ready=0, the module SHALL:
- hold the IF/ID register if stall_D=1;
- otherwise insert a bubble (valid_D<=0; instr_D and pc_D held).
REQ-021 In HOLD, imem_req SHALL be 0; while stall_D=1, all state SHALL hold.
REQ-022 In HOLD with stall_D=0, the module SHALL:
- load instr_D<=skid, pc_D<=PC, valid_D<=1;
- set PC<=PC+4;
- go to FETCH.
REQ-023 When pcsrc_M=1 in FETCH or HOLD, the module SHALL, with priority over stall_D and imem_ready:
- set PC<={branch_target_M[N-1:2],2'b00};
- set valid_D<=0 (flush);
- discard the skid register and any same-cycle imem_rdata;
- go to FETCH.
REQ-024 pcsrc_M SHALL be ignored in BOOT.
REQ-025 The module SHALL never present the same instruction twice nor skip one, absent a redirect.

Reset
REQ-026 While reset_n=0, state SHALL be BOOT, PC=RESET_PC, instr_D=0, pc_D=0, valid_D=0, skid=0, imem_req=0, imem_addr=RESET_PC.
REQ-027 Reset assertion mid-transaction SHALL abandon any outstanding fetch immediately, asynchronously.

Verification
REQ-028 Reset release, imem_ready held 1, stall_D=0 -> imem_req rises 1 cycle after release; valid_D=1 with pc_D=0,4,8 on consecutive cycles.
REQ-029 imem_ready=0 for 3 cycles at PC=0x10 -> imem_addr stable at 0x10; valid_D=0 for those cycles; then instr_D=rdata, pc_D=0x10.
REQ-030 stall_D=1 for 2 cycles when rdata=0xF8400000 arrives at PC=0x20 -> IF/ID unchanged and imem_req=0 while stalled; after release instr_D=0xF8400000, pc_D=0x20, next imem_addr=0x24.
REQ-031 pcsrc_M=1 with target 0x103 in HOLD while stall_D=1 -> valid_D=0, skid dropped, next imem_addr=0x100.
REQ-032 pcsrc_M=1 and imem_ready=1 in the same cycle -> returned word never reaches instr_D; the next fetch is at the target.
REQ-033 PC=2^N-4 fetched -> next imem_addr=0.

Source files
------------

// File: rtl/fetch_ifid.sv
// rtl/fetch_ifid.sv - instruction fetch stage with IF/ID pipeline register and stall skid
module fetch_ifid #(
    parameter int          N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall_D,
    input  logic         pcsrc_M,
    input  logic [N-1:0] branch_target_M,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] pc;
    logic [31:0]  skid;
    logic [N-1:0] redirect_pc;
    logic [N-1:0] pc_next_seq;

    assign redirect_pc = branch_target_M & ~N'(3);
    assign pc_next_seq = pc + N'(4);
    assign imem_addr   = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            skid     <= '0;
            instr_D  <= '0;
            pc_D     <= '0;
            valid_D  <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (pcsrc_M) begin
                        // Redirect wins: the word returning this cycle belongs to the wrong path.
                        pc      <= redirect_pc;
                        valid_D <= 1'b0;
                        skid    <= '0;
                    end else if (imem_ready && !stall_D) begin
                        instr_D <= imem_rdata;
                        pc_D    <= pc;
                        valid_D <= 1'b1;
                        pc      <= pc_next_seq;
                    end else if (imem_ready) begin
                        skid     <= imem_rdata;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end else if (!stall_D) begin
                        valid_D <= 1'b0;
                    end
                end
                HOLD: begin
                    if (pcsrc_M) begin
                        pc       <= redirect_pc;
                        valid_D  <= 1'b0;
                        skid     <= '0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (!stall_D) begin
                        instr_D  <= skid;
                        pc_D     <= pc;
                        valid_D  <= 1'b1;
                        pc       <= pc_next_seq;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// tb/tb_fetch_ifid.sv - scoreboard bench for fetch_ifid
module tb_fetch_ifid;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         stall_D;
    logic         pcsrc_M;
    logic [N-1:0] branch_target_M;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr_D;
    logic [N-1:0] pc_D;
    logic         valid_D;

    fetch_ifid #(.N(N), .RESET_PC('0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_D         (stall_D),
        .pcsrc_M         (pcsrc_M),
        .branch_target_M (branch_target_M),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_D         (instr_D),
        .pc_D            (pc_D),
        .valid_D         (valid_D)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } fetch_t;

    fetch_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // Expected fetch-side and IF/ID state, tracked at transaction level.
    typedef enum int { M_BOOT, M_FETCH, M_HOLD } mstate_t;
    mstate_t      m_state;
    logic [N-1:0] m_pc;
    logic         m_valid;
    logic [31:0]  m_instr;
    logic [N-1:0] m_pcd;
    int           cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [N-1:0] a);
        if (a == 64'h20) return 32'hF840_0000;
        return (a[31:0] * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = '0;
        m_valid = 1'b0;
        m_instr = '0;
        m_pcd   = '0;
        sb_q.delete();
    endtask

    task automatic check_ifid();
        check("valid_D", 64'(valid_D), 64'(m_valid));
        check("instr_D", 64'(instr_D), 64'(m_instr));
        check("pc_D", pc_D, m_pcd);
    endtask

    task automatic load_from_queue();
        fetch_t f;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            f = sb_q.pop_front();
            m_instr = f.instr;
            m_pcd   = f.pc;
            m_valid = 1'b1;
        end
    endtask

    // One clock: drive inputs, check fetch outputs, advance model, check IF/ID after the edge.
    task automatic cycle(input logic rdy, input logic stl, input logic br, input logic [N-1:0] tgt);
        imem_ready      = rdy;
        stall_D         = stl;
        pcsrc_M         = br;
        branch_target_M = tgt;
        imem_rdata      = rdy ? mem_word(m_pc) : (32'hBAD0_0000 ^ 32'(cyc));
        check("imem_req", 64'(imem_req), 64'(m_state == M_FETCH));
        if (m_state == M_FETCH) check("imem_addr", imem_addr, m_pc);
        case (m_state)
            M_BOOT: m_state = M_FETCH;
            M_FETCH: begin
                if (br) begin
                    m_pc    = tgt & ~64'd3;
                    m_valid = 1'b0;
                end else if (rdy) begin
                    sb_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    if (!stl) begin
                        load_from_queue();
                        m_pc = m_pc + 64'd4;
                    end else begin
                        m_state = M_HOLD;
                    end
                end else if (!stl) begin
                    m_valid = 1'b0;
                end
            end
            M_HOLD: begin
                if (br) begin
                    void'(sb_q.pop_front());
                    m_pc    = tgt & ~64'd3;
                    m_valid = 1'b0;
                    m_state = M_FETCH;
                end else if (!stl) begin
                    load_from_queue();
                    m_pc    = m_pc + 64'd4;
                    m_state = M_FETCH;
                end
            end
            default: m_state = M_BOOT;
        endcase
        @(posedge clk);
        #1;
        cyc++;
        check_ifid();
    endtask

    initial begin
        reset_n         = 1'b0;
        stall_D         = 1'b0;
        pcsrc_M         = 1'b0;
        branch_target_M = '0;
        imem_ready      = 1'b0;
        imem_rdata      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", imem_addr, 64'd0);
        check_ifid();
        reset_n = 1'b1;

        // Streaming from reset: BOOT then pc_D 0,4,8,c
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        // Memory wait at 0x10
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("wait_pc_D", pc_D, 64'h10);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        // Stall while 0xF8400000 returns at 0x20
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("skid_instr", 64'(instr_D), 64'hF840_0000);
        check("skid_next_addr", imem_addr, 64'h24);
        // Redirect while holding a skid word
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 64'h103);
        check("hold_redirect_addr", imem_addr, 64'h100);
        cycle(1'b1, 1'b0, 1'b0, '0);
        // Redirect coinciding with a returned word
        cycle(1'b1, 1'b0, 1'b1, 64'h200);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("redirect_pc_D", pc_D, 64'h200);
        // PC wrap-around
        cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("wrap_addr", imem_addr, 64'h0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 19) == 0), 64'($urandom) << 4);
        end
        // Asynchronous reset mid-fetch
        imem_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_imem_req", 64'(imem_req), 64'd0);
        check("async_imem_addr", imem_addr, 64'd0);
        check_ifid();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
